// File: rtl/otter_mmio_hub.sv
// Memory-mapped I/O hub for the OTTER IOBUS: generic R/W slots with write strobes,
// a synchronised switch port and a sticky, maskable button-event latch driving INTR.
module otter_mmio_hub #(
  parameter int          N_OUT   = 6,
  parameter int          OUT_W   = 16,
  parameter int          SW_W    = 16,
  parameter int          EVT_W   = 5,
  parameter logic [31:0] BASE_AD = 32'h11000000,
  parameter logic [31:0] STRIDE  = 32'h00040000
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [31:0]            IOBUS_ADDR,
  input  logic [31:0]            IOBUS_OUT,
  input  logic                   IOBUS_WR,
  input  logic                   IOBUS_RD,
  output logic [31:0]            IOBUS_IN,
  input  logic [SW_W-1:0]        SWITCHES,
  input  logic [EVT_W-1:0]       EVENTS,
  output logic [N_OUT*OUT_W-1:0] OUT_REGS,
  output logic [N_OUT-1:0]       WSTB,
  output logic                   INTR
);

  localparam int SW_SLOT   = N_OUT;
  localparam int STAT_SLOT = N_OUT + 1;
  localparam int MASK_SLOT = N_OUT + 2;
  localparam int N_SLOT    = N_OUT + 3;

  logic [N_OUT-1:0][OUT_W-1:0] r_out;
  logic [N_OUT-1:0]            r_wstb;
  logic [SW_W-1:0]             r_sw1, r_sw2;
  logic [EVT_W-1:0]            r_ev1, r_ev2, r_evPrev;
  logic [EVT_W-1:0]            r_stat, r_mask;
  logic [1:0]                  r_arm;

  logic [N_SLOT-1:0]           w_hit;
  logic [31:0]                 w_rdata;
  logic                        w_armed;
  logic [EVT_W-1:0]            w_edge;
  logic [EVT_W-1:0]            w_clr;
  logic                        w_unused;

  // Upper write-data bits beyond a slot's width are intentionally discarded.
  assign w_unused = ^IOBUS_OUT;

  // Exact-match decode: one hit bit per slot.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < N_SLOT; k++)
      w_hit[k] = (IOBUS_ADDR == (BASE_AD + STRIDE * 32'(k)));
  end

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < N_OUT; k++)
      if (w_hit[k]) w_rdata[OUT_W-1:0] = r_out[k];
    if (w_hit[SW_SLOT])   w_rdata[SW_W-1:0]  = r_sw2;
    if (w_hit[STAT_SLOT]) w_rdata[EVT_W-1:0] = r_stat;
    if (w_hit[MASK_SLOT]) w_rdata[EVT_W-1:0] = r_mask;
  end

  assign IOBUS_IN = w_rdata;

  // Edges are ignored until three clocks after reset so held-high inputs stay quiet.
  assign w_armed = (r_arm == 2'd3);
  assign w_edge  = w_armed ? (r_ev2 & ~r_evPrev) : '0;

  always_comb begin
    w_clr = '0;
    if (w_hit[STAT_SLOT] && IOBUS_RD) w_clr = r_stat;
    if (w_hit[STAT_SLOT] && IOBUS_WR) w_clr = w_clr | IOBUS_OUT[EVT_W-1:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_out  <= '0;
      r_wstb <= '0;
    end else begin
      r_wstb <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        if (IOBUS_WR && w_hit[k]) begin
          r_out[k]  <= IOBUS_OUT[OUT_W-1:0];
          r_wstb[k] <= 1'b1;
        end
      end
    end
  end

  // A new edge is OR-ed in after the clear, so a set on the clearing edge survives.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sw1    <= '0;
      r_sw2    <= '0;
      r_ev1    <= '0;
      r_ev2    <= '0;
      r_evPrev <= '0;
      r_arm    <= '0;
      r_stat   <= '0;
      r_mask   <= '0;
    end else begin
      r_sw1    <= SWITCHES;
      r_sw2    <= r_sw1;
      r_ev1    <= EVENTS;
      r_ev2    <= r_ev1;
      r_evPrev <= r_ev2;
      if (!w_armed) r_arm <= r_arm + 2'd1;
      r_stat   <= (r_stat & ~w_clr) | w_edge;
      if (IOBUS_WR && w_hit[MASK_SLOT]) r_mask <= IOBUS_OUT[EVT_W-1:0];
    end
  end

  assign OUT_REGS = r_out;
  assign WSTB     = r_wstb;
  assign INTR     = |(r_stat & r_mask);

endmodule

// File: doc/otter_mmio_hub.md
# otter_mmio_hub

Parametrised memory-mapped I/O hub for the OTTER MCU IOBUS. It replaces a hand-coded per-peripheral address `case` with:

- N generic write/readback registers, each with a one-cycle write strobe.
- A synchronised switch input port.
- A sticky, maskable button-event latch that drives the MCU interrupt line.

It sits between `OTTER_MCU` (IOBUS_*) and the board peripherals: LEDs, 7-seg, VGA framebuffer, switches and buttons.

## Interface
Parameters:
- `N_OUT`, 6, number of write/readback register slots (1..16)
- `OUT_W`, 16, width of each register slot (1..32)
- `SW_W`, 16, switch input width (1..32)
- `EVT_W`, 5, button/event input width (1..32)
- `BASE_AD`, 32'h11000000, address of slot 0
- `STRIDE`, 32'h00040000, address step between slots

Ports (one clock; reset is asynchronous, active-low):
- `CLK`, in, 1, MCU clock; all state on rising edge
- `RESET_N`, in, 1, asynchronous active-low reset
- `IOBUS_ADDR`, in, 32, bus address
- `IOBUS_OUT`, in, 32, write data from MCU
- `IOBUS_WR`, in, 1, write qualifier
- `IOBUS_RD`, in, 1, read qualifier; used only for clear-on-read
- `IOBUS_IN`, out, 32, read data to MCU (combinational)
- `SWITCHES`, in, SW_W, raw asynchronous switches
- `EVENTS`, in, EVT_W, debounced, asynchronous-safe button levels
- `OUT_REGS`, out, N_OUT*OUT_W, slot k is bits [k*OUT_W +: OUT_W]
- `WSTB`, out, N_OUT, one-cycle pulse per slot write
- `INTR`, out, 1, interrupt request

## Operation
Address map: slot k is at `BASE_AD + k*STRIDE`. Only an exact address match selects a slot.
- Slots 0..N_OUT-1: R/W register. A write stores `IOBUS_OUT[OUT_W-1:0]`; a read returns the value zero-extended.
- Slot N_OUT (SW): read-only. Returns synchronised switches, zero-extended. Writes are ignored.
- Slot N_OUT+1 (EVT_STAT): sticky event bits.
  - Read returns the status.
  - A read with `IOBUS_RD`=1 clears the bits returned.
  - A write clears the bits where `IOBUS_OUT`=1 (write-1-to-clear).
- Slot N_OUT+2 (EVT_MASK): R/W interrupt mask, `EVT_W` bits.
- Unmapped address: read 0, write ignored, no strobe.

Input path:
- `SWITCHES` and `EVENTS` each pass through a 2-flop synchroniser.
- Event edge = `sync2 & ~prev` per bit, where `prev` is `sync2` delayed one cycle.
- Rising edge sets the status bit; falling edges are ignored.
- Arming: edge detection is suppressed for the first 3 rising CLK edges after `RESET_N` rises. `prev` tracks `sync2` during this window, so an input held high through reset produces no event.
- Simultaneous clear and new edge on the same bit: set wins, and the bit stays 1.

`INTR` = `|(EVT_STAT & EVT_MASK)`, driven from registered state only (no bus-input paths).

Width rules:
- Read data above slot width returns 0.
- `IOBUS_OUT` bits above slot width are discarded.

Reset (async, `RESET_N`=0): the following are all 0 and stay 0 while `RESET_N`=0.
- `OUT_REGS`
- `WSTB`
- status, mask, synchronisers, `prev`, arm counter
- therefore `INTR`

`IOBUS_IN` remains a combinational function of the (reset) state.

## Timing
- Write: `IOBUS_WR`=1 with slot-k address at edge n.
  - `OUT_REGS[k]` is updated after edge n.
  - `WSTB[k]`=1 for exactly the cycle between edges n and n+1.
  - Back-to-back writes give back-to-back pulses.
- Read: `IOBUS_IN` is valid in the same cycle as `IOBUS_ADDR`, with zero-cycle latency.
- Readback of slot k written at edge n returns the new value from cycle n+1.
- Event latency: `EVENTS[b]` rises and is stable before edge 0.
  - `sync1`=1 at edge 0, `sync2`=1 at edge 1.
  - Status bit set at edge 2, so `INTR` (if masked in) is high after edge 2.
- Clear-on-read/W1C: the clear takes effect at the edge that samples the access. The status read during that cycle shows the pre-clear value.
- Switch latency: 2 edges from input change to read value.
- Reset asserted mid-operation: all state zero immediately (asynchronous). A pending `WSTB` pulse is truncated.

## Test plan
- Write 16'hBEEF to slot 2 (`IOBUS_WR`, addr 32'h11080000):
  - `WSTB`=6'b000100 for one cycle only.
  - `OUT_REGS` slot 2 = 16'hBEEF.
  - Read at 32'h11080000 returns 32'h0000BEEF.
  - Write of 32'hFFFF1234 reads back 32'h00001234.
- Raise `EVENTS[3]`, mask = 5'b01000:
  - Status reads 5'b01000 and `INTR`=1 two edges after the input rises.
  - Read EVT_STAT with `IOBUS_RD`=1 → next cycle status 0, `INTR`=0.
  - Repeat with `EVENTS[1]` edge landing on the clear edge → status 5'b00010 survives.
- W1C: status 5'b10101, write 32'h00000005 to EVT_STAT → status 5'b10000. With mask 5'b00101, `INTR` drops.
- Hold `EVENTS`=5'b11111 through reset, release `RESET_N`:
  - Status stays 0 for 20 cycles.
  - Toggle bit 0 low then high → status 5'b00001.
- Unmapped address 32'h11000004 and 32'h11300000:
  - Reads return 0.
  - Writes change no register and no `WSTB`.
- Assert `RESET_N`=0 during an active `WSTB` pulse with `OUT_REGS`≠0 and status≠0: `WSTB`, `OUT_REGS`, status, mask and `INTR` go to 0 without waiting for a clock edge.
